// File: rtl/rob_ctrl.sv
// Reorder-buffer sequencing controller: head/tail pointers, occupancy and
// per-entry completion status. Entry payloads live elsewhere; this block only
// decides who may allocate, which entry may retire, and when to flush.

package rob_pkg;
  localparam int ROB_ENTRIES = 128;

  // READY doubles as "free": an entry not currently owned by an instruction.
  typedef enum logic [1:0] {
    READY     = 2'd0,
    ISSUED    = 2'd1,
    DONE      = 2'd2,
    EXCEPTION = 2'd3
  } status_t;
endpackage

module rob_ctrl #(
  parameter int ROB_ENTRIES = rob_pkg::ROB_ENTRIES,
  parameter int PTR_W       = $clog2(ROB_ENTRIES)
) (
  input  logic             clk_in,
  input  logic             rst_N_in,
  input  logic             alloc_valid_in,
  output logic             alloc_ready_out,
  output logic [PTR_W-1:0] alloc_ptr_out,
  input  logic             wb_valid_in,
  input  logic [PTR_W-1:0] wb_ptr_in,
  input  logic             wb_exc_in,
  output logic             commit_valid_out,
  input  logic             commit_ready_in,
  output logic [PTR_W-1:0] commit_ptr_out,
  output logic             flush_out,
  output logic [PTR_W-1:0] flush_ptr_out,
  output logic [PTR_W:0]   count_out,
  output logic             empty_out,
  output logic             full_out
);

  localparam int CW = PTR_W + 1;
  localparam logic [PTR_W:0] CNT_FULL = CW'(ROB_ENTRIES);

  typedef enum logic {
    S_RUN   = 1'b0,
    S_FLUSH = 1'b1
  } fsm_t;

  fsm_t                state_q, state_d;
  logic [PTR_W-1:0]    head_q, head_d;
  logic [PTR_W-1:0]    tail_q, tail_d;
  logic [PTR_W:0]      count_q, count_d;
  rob_pkg::status_t    status_q [ROB_ENTRIES];
  rob_pkg::status_t    status_d [ROB_ENTRIES];

  logic is_empty;
  logic is_full;
  logic head_exc;
  logic head_done;
  logic alloc_fire;
  logic commit_fire;
  logic wb_accept;

  // Occupancy flags come from the count so a full buffer is never mistaken
  // for an empty one when head and tail coincide.
  assign is_empty  = (count_q == '0);
  assign is_full   = (count_q == CNT_FULL);
  assign head_exc  = !is_empty && (status_q[head_q] == rob_pkg::EXCEPTION);
  assign head_done = !is_empty && (status_q[head_q] == rob_pkg::DONE);

  assign alloc_fire  = alloc_valid_in & alloc_ready_out;
  assign commit_fire = commit_valid_out & commit_ready_in;
  // Only an entry that is genuinely in flight may complete; late or duplicate
  // completions to free/finished entries are dropped silently.
  assign wb_accept   = (state_q == S_RUN) && wb_valid_in &&
                       (status_q[wb_ptr_in] == rob_pkg::ISSUED);

  // FSM state register
  always_ff @(posedge clk_in) begin
    if (!rst_N_in) begin
      state_q <= S_RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state: an excepting head triggers a single flush cycle
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_RUN:   if (head_exc) state_d = S_FLUSH;
      S_FLUSH: state_d = S_RUN;
      default: state_d = S_RUN;
    endcase
  end

  // FSM outputs: handshakes depend on registered state only
  always_comb begin
    alloc_ready_out  = 1'b0;
    commit_valid_out = 1'b0;
    flush_out        = 1'b0;
    case (state_q)
      S_RUN: begin
        alloc_ready_out  = !is_full && !head_exc;
        commit_valid_out = head_done;
      end
      S_FLUSH: flush_out = 1'b1;
      default: ;
    endcase
  end

  assign alloc_ptr_out  = tail_q;
  assign commit_ptr_out = head_q;
  assign flush_ptr_out  = head_q;
  assign count_out      = count_q;
  assign empty_out      = is_empty;
  assign full_out       = is_full;

  // Pointer and occupancy next state; a flush rewinds tail onto head
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (state_q == S_FLUSH) begin
      tail_d  = head_q;
      count_d = '0;
    end else begin
      if (commit_fire) head_d = head_q + PTR_W'(1);
      if (alloc_fire)  tail_d = tail_q + PTR_W'(1);
      case ({alloc_fire, commit_fire})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Per-entry status next state; alloc, wb and commit never hit the same entry
  always_comb begin
    status_d = status_q;
    if (state_q == S_FLUSH) begin
      for (int i = 0; i < ROB_ENTRIES; i++) begin
        status_d[i] = rob_pkg::READY;
      end
    end else begin
      if (alloc_fire)  status_d[tail_q]    = rob_pkg::ISSUED;
      if (wb_accept)   status_d[wb_ptr_in] = wb_exc_in ? rob_pkg::EXCEPTION : rob_pkg::DONE;
      if (commit_fire) status_d[head_q]    = rob_pkg::READY;
    end
  end

  // Datapath registers
  always_ff @(posedge clk_in) begin
    if (!rst_N_in) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      for (int i = 0; i < ROB_ENTRIES; i++) begin
        status_q[i] <= rob_pkg::READY;
      end
    end else begin
      head_q   <= head_d;
      tail_q   <= tail_d;
      count_q  <= count_d;
      status_q <= status_d;
    end
  end

endmodule

// File: tb/tb_rob_ctrl.sv
// Scoreboard bench for rob_ctrl. The reference model is an age-ordered queue
// of live entries; expected per-cycle outputs are queued by the driver and
// popped/compared by an independent monitor at the falling edge.

module tb_rob_ctrl;
  localparam int N = 128;

  logic       clk_in = 1'b0;
  logic       rst_N_in = 1'b0;
  logic       alloc_valid_in = 1'b0;
  logic       alloc_ready_out;
  logic [6:0] alloc_ptr_out;
  logic       wb_valid_in = 1'b0;
  logic [6:0] wb_ptr_in = '0;
  logic       wb_exc_in = 1'b0;
  logic       commit_valid_out;
  logic       commit_ready_in = 1'b0;
  logic [6:0] commit_ptr_out;
  logic       flush_out;
  logic [6:0] flush_ptr_out;
  logic [7:0] count_out;
  logic       empty_out;
  logic       full_out;

  rob_ctrl dut (
    .clk_in           (clk_in),
    .rst_N_in         (rst_N_in),
    .alloc_valid_in   (alloc_valid_in),
    .alloc_ready_out  (alloc_ready_out),
    .alloc_ptr_out    (alloc_ptr_out),
    .wb_valid_in      (wb_valid_in),
    .wb_ptr_in        (wb_ptr_in),
    .wb_exc_in        (wb_exc_in),
    .commit_valid_out (commit_valid_out),
    .commit_ready_in  (commit_ready_in),
    .commit_ptr_out   (commit_ptr_out),
    .flush_out        (flush_out),
    .flush_ptr_out    (flush_ptr_out),
    .count_out        (count_out),
    .empty_out        (empty_out),
    .full_out         (full_out)
  );

  always #5 clk_in = ~clk_in;

  // ---------------- reference model ----------------
  localparam int ST_ISS  = 1;
  localparam int ST_DONE = 2;
  localparam int ST_EXC  = 3;

  typedef struct {
    int idx;
    int st;
  } ent_t;

  typedef struct {
    bit known;
    bit av;
    bit cr;
    bit ar;
    bit cv;
    bit fl;
    int aptr;
    int cptr;
    int fptr;
    int cnt;
  } exp_t;

  ent_t m_q[$];       // live entries, oldest first
  int   m_head  = 0;
  bit   m_flush = 0;
  bit   m_known = 0;

  exp_t exp_q[$];

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  task automatic check(input string name, input int act, input int expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, expv);
    end
  endtask

  function automatic int pick_wb_ptr();
    int iss[$];
    foreach (m_q[i]) if (m_q[i].st == ST_ISS) iss.push_back(m_q[i].idx);
    if (iss.size() > 0 && $urandom_range(7, 0) != 0)
      return iss[$urandom_range(iss.size() - 1, 0)];
    return $urandom_range(N - 1, 0);
  endfunction

  // Drive one cycle of inputs, queue the expected outputs for that cycle,
  // then advance the model to the state after the next rising edge.
  task automatic step(input bit rst_n, input bit av, input bit wv, input int wp,
                      input bit we, input bit cr);
    exp_t e;
    bit   hexc;
    int   tail;
    @(posedge clk_in);
    #1;
    rst_N_in        = rst_n;
    alloc_valid_in  = av;
    wb_valid_in     = wv;
    wb_ptr_in       = 7'(wp);
    wb_exc_in       = we;
    commit_ready_in = cr;

    hexc   = (m_q.size() > 0) && (m_q[0].st == ST_EXC);
    tail   = (m_head + m_q.size()) % N;
    e.known = m_known;
    e.av    = av;
    e.cr    = cr;
    e.fl    = m_flush;
    e.ar    = !m_flush && (m_q.size() < N) && !hexc;
    e.cv    = !m_flush && (m_q.size() > 0) && (m_q[0].st == ST_DONE);
    e.aptr  = tail;
    e.cptr  = m_head;
    e.fptr  = m_head;
    e.cnt   = m_q.size();
    exp_q.push_back(e);

    if (!rst_n) begin
      m_q.delete();
      m_head  = 0;
      m_flush = 0;
      m_known = 1;
    end else if (m_known) begin
      if (m_flush) begin
        m_q.delete();
        m_flush = 0;
      end else begin
        if (wv) begin
          foreach (m_q[i])
            if (m_q[i].idx == wp && m_q[i].st == ST_ISS) m_q[i].st = we ? ST_EXC : ST_DONE;
        end
        if (cr && e.cv) begin
          void'(m_q.pop_front());
          m_head = (m_head + 1) % N;
        end
        if (av && e.ar) m_q.push_back('{idx: tail, st: ST_ISS});
        m_flush = hexc;
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1, 0, 0, 0, 0, 0);
  endtask

  task automatic do_reset();
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk_in) begin
    exp_t e;
    cyc++;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      if (e.known) begin
        check("alloc_ready", int'(alloc_ready_out), int'(e.ar));
        check("commit_valid", int'(commit_valid_out), int'(e.cv));
        check("flush", int'(flush_out), int'(e.fl));
        check("count", int'(count_out), e.cnt);
        check("empty", int'(empty_out), int'(e.cnt == 0));
        check("full", int'(full_out), int'(e.cnt == N));
        if (e.ar) check("alloc_ptr", int'(alloc_ptr_out), e.aptr);
        if (e.cv) check("commit_ptr", int'(commit_ptr_out), e.cptr);
        if (e.fl) check("flush_ptr", int'(flush_ptr_out), e.fptr);
        if (e.av && e.ar) $display("cycle %0d alloc ptr=%0d count=%0d", cyc, e.aptr, e.cnt);
        if (e.cr && e.cv) $display("cycle %0d commit ptr=%0d count=%0d", cyc, e.cptr, e.cnt);
        if (e.fl)         $display("cycle %0d flush ptr=%0d", cyc, e.fptr);
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    // Reset, three back-to-back allocations
    do_reset();
    for (int i = 0; i < 3; i++) step(1, 1, 0, 0, 0, 0);
    idle(1);
    // Out-of-order completion, in-order retire
    step(1, 0, 1, 1, 0, 1);
    step(1, 0, 1, 0, 0, 1);
    for (int i = 0; i < 4; i++) step(1, 0, 0, 0, 0, 1);

    // Fill to capacity, then commit with alloc held: wrap to index 0
    do_reset();
    for (int i = 0; i < N; i++) step(1, 1, 0, 0, 0, 0);
    step(1, 1, 1, 0, 0, 0);
    step(1, 1, 0, 0, 0, 1);
    step(1, 1, 0, 0, 0, 0);
    step(1, 1, 0, 0, 0, 0);
    idle(2);

    // Exception at head flushes the buffer
    do_reset();
    for (int i = 0; i < 5; i++) step(1, 1, 0, 0, 0, 0);
    step(1, 0, 1, 0, 1, 1);
    for (int i = 0; i < 4; i++) step(1, 0, 0, 0, 0, 1);
    step(1, 1, 0, 0, 0, 1);
    idle(2);

    // Writebacks to free and already-done entries are ignored
    do_reset();
    for (int i = 0; i < 2; i++) step(1, 1, 0, 0, 0, 0);
    step(1, 0, 1, 7, 0, 0);
    step(1, 0, 1, 0, 0, 0);
    step(1, 0, 1, 0, 1, 0);
    step(1, 0, 1, 7, 1, 0);
    idle(2);
    step(1, 0, 0, 0, 0, 1);
    idle(1);

    // Reset asserted during the flush cycle
    do_reset();
    for (int i = 0; i < 2; i++) step(1, 1, 0, 0, 0, 0);
    step(1, 0, 1, 0, 1, 0);
    step(1, 1, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0, 1);
    step(1, 0, 0, 0, 0, 0);
    idle(1);

    // Randomized traffic; phases alternate retire pressure to reach full
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      bit slow = ((i / 400) % 2) == 1;
      bit rn   = $urandom_range(799, 0) != 0;
      bit av   = $urandom_range(3, 0) != 0;
      bit wv   = $urandom_range(1, 0) != 0;
      int wp   = pick_wb_ptr();
      bit we   = $urandom_range(59, 0) == 0;
      bit cr   = slow ? ($urandom_range(7, 0) == 0) : ($urandom_range(2, 0) != 0);
      step(rn, av, wv, wp, we, cr);
    end
    idle(3);

    @(negedge clk_in);
    #1;
    check("scoreboard_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
